// File: rtl/spi_flash_pkg.sv
// Shared opcodes, page geometry and FSM encoding for the SPI flash page writer.
package spi_flash_pkg;
  localparam logic [7:0] OP_WREN   = 8'h06;
  localparam logic [7:0] OP_PP     = 8'h02;
  localparam logic [7:0] OP_RDSR   = 8'h05;
  localparam int         PAGE_SIZE = 256;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WREN,
    S_GAP,
    S_CMD,
    S_DATA,
    S_POLL,
    S_DONE,
    S_ERR
  } wr_state_t;
endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte engine: shifts one byte out MSB first while sampling MISO on SCK rise.
module spi_byte_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       busy,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh;
  logic          tick;

  assign tick = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      byte_done <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      rx_byte   <= '0;
    end else begin
      byte_done <= 1'b0;
      if (load && !busy) begin
        // first bit is presented while SCK is still low
        busy    <= 1'b1;
        sh      <= tx_byte;
        mosi    <= tx_byte[7];
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (busy) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          sck <= ~sck;
          if (!sck) begin
            rx_byte <= {rx_byte[6:0], miso};
          end else if (bit_cnt == 3'd7) begin
            busy      <= 1'b0;
            byte_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            sh      <= {sh[6:0], 1'b0};
            mosi    <= sh[6];
          end
        end
      end
    end
  end
endmodule

// File: rtl/spi_flash_writer.sv
// Programs one flash page: WREN, PAGE PROGRAM with streamed data, then RDSR polling until WIP clears.
module spi_flash_writer
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int CS_GAP   = 4,
  parameter int POLL_MAX = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [8:0]  len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  localparam int GAP_CYC = CS_GAP * CLK_DIV;
  localparam int GW      = $clog2(GAP_CYC + 1);
  localparam int PW      = $clog2(POLL_MAX + 1);

  wr_state_t     state, state_n;
  logic [23:0]   addr_q;
  logic [8:0]    remain;
  logic [1:0]    idx;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] poll_cnt;
  logic          prog_sent;
  logic          sh_load, sh_busy, sh_done;
  logic [7:0]    sh_tx, sh_rx;
  logic          req_bad, hs, gap_end, poll_last, wip, unused_rx;

  assign req_bad   = (len == '0) || (len > 9'(PAGE_SIZE)) ||
                     (({2'b00, addr[7:0]} + {1'b0, len}) > 10'(PAGE_SIZE));
  assign hs        = wr_valid && wr_ready;
  assign gap_end   = (gap_cnt == GW'(GAP_CYC - 1));
  assign poll_last = (poll_cnt == PW'(POLL_MAX - 1));
  assign wip       = sh_rx[0];
  assign unused_rx = ^sh_rx[7:1];

  assign busy = !(state inside {S_IDLE, S_DONE, S_ERR});
  assign done = (state == S_DONE);
  assign err  = (state == S_ERR);

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .tx_byte  (sh_tx),
    .rx_byte  (sh_rx),
    .byte_done(sh_done),
    .busy     (sh_busy),
    .sck      (spi_sck),
    .mosi     (spi_mosi),
    .miso     (spi_miso)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      spi_cs_n <= 1'b1;
    end else begin
      state    <= state_n;
      spi_cs_n <= !(state_n inside {S_WREN, S_CMD, S_DATA, S_POLL});
    end
  end

  // A new byte is only loaded once the previous byte_done has been absorbed,
  // which leaves SCK low for a cycle between bytes.
  always_comb begin
    state_n  = state;
    sh_load  = 1'b0;
    sh_tx    = OP_WREN;
    wr_ready = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = req_bad ? S_ERR : S_WREN;
      S_WREN: begin
        sh_load = !sh_busy && !sh_done;
        if (sh_done) state_n = S_GAP;
      end
      S_GAP: if (gap_end) state_n = prog_sent ? S_POLL : S_CMD;
      S_CMD: begin
        case (idx)
          2'd0:    sh_tx = OP_PP;
          2'd1:    sh_tx = addr_q[23:16];
          2'd2:    sh_tx = addr_q[15:8];
          default: sh_tx = addr_q[7:0];
        endcase
        sh_load = !sh_busy && !sh_done;
        if (sh_done && idx == 2'd3) state_n = S_DATA;
      end
      S_DATA: begin
        wr_ready = !sh_busy && !sh_done && (remain != '0);
        sh_tx    = wr_data;
        sh_load  = hs;
        if (sh_done && remain == '0) state_n = S_GAP;
      end
      S_POLL: begin
        sh_tx   = idx[0] ? 8'h00 : OP_RDSR;
        sh_load = !sh_busy && !sh_done;
        if (sh_done && idx == 2'd1)
          state_n = !wip ? S_DONE : (poll_last ? S_ERR : S_GAP);
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      remain    <= '0;
      idx       <= '0;
      gap_cnt   <= '0;
      poll_cnt  <= '0;
      prog_sent <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        addr_q    <= addr;
        remain    <= len;
        poll_cnt  <= '0;
        prog_sent <= 1'b0;
      end
      if (hs) remain <= remain - 1'b1;
      if (state == S_DATA) prog_sent <= 1'b1;
      gap_cnt <= (state == S_GAP && !gap_end) ? gap_cnt + 1'b1 : '0;
      if (state_n != state) idx <= '0;
      else if (sh_done)     idx <= idx + 1'b1;
      if (state == S_POLL && sh_done && idx == 2'd1 && poll_cnt != PW'(POLL_MAX))
        poll_cnt <= poll_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_flash_writer.sv
// Directed/randomized bench: behavioural SPI flash on the pins plus a byte-stream source.
module tb_spi_flash_writer;
  localparam int CLK_DIV = 2, CS_GAP = 4, POLL_MAX = 16, LIMIT = 30000;

  logic        clk = 1'b0;
  logic        rst, start, wr_valid, wr_ready, busy, done, err;
  logic        spi_sck, spi_cs_n, spi_mosi, spi_miso;
  logic [23:0] addr;
  logic [8:0]  len;
  logic [7:0]  wr_data;

  always #5 clk = ~clk;

  spi_flash_writer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .len(len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .busy(busy), .done(done), .err(err),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- flash model ----------------
  logic [7:0] mem [int];
  int         log_op[$];
  logic [7:0] fr[$];
  logic [7:0] last_prog[$];
  int         last_rises = 0, rises = 0, wip_left = 0, wip_cfg = 0;
  bit         wel = 1'b0;

  initial begin
    logic ps, pc;
    logic [7:0] sh, stat;
    logic [23:0] a, wa;
    int nbits;
    spi_miso = 1'b0; ps = 1'b0; pc = 1'b1; sh = '0; stat = '0; nbits = 0;
    forever begin
      @(spi_sck or spi_cs_n);
      if (pc === 1'b1 && spi_cs_n === 1'b0) begin
        fr.delete(); nbits = 0; rises = 0;
        stat = {7'b0, wip_left > 0};
      end
      if (ps === 1'b0 && spi_sck === 1'b1 && spi_cs_n === 1'b0) begin
        sh = {sh[6:0], spi_mosi}; nbits++; rises++;
        if (nbits % 8 == 0) fr.push_back(sh);
      end
      if (ps === 1'b1 && spi_sck === 1'b0 && spi_cs_n === 1'b0 && nbits >= 8 && fr[0] == 8'h05)
        spi_miso = stat[7 - (nbits % 8)];
      if (pc === 1'b0 && spi_cs_n === 1'b1) begin
        log_op.push_back(fr.size() > 0 ? int'(fr[0]) : -1);
        if (nbits % 8 == 0 && fr.size() > 0) begin
          if (fr.size() == 1 && fr[0] == 8'h06) wel = 1'b1;
          else if (fr[0] == 8'h02 && wel && fr.size() >= 5) begin
            a = {fr[1], fr[2], fr[3]};
            for (int i = 4; i < fr.size(); i++) begin
              wa = {a[23:8], 8'(a[7:0] + 8'(i - 4))};
              mem[int'(wa)] = fr[i];
            end
            last_prog = fr;
            last_rises = rises;
            wip_left = wip_cfg;
            wel = 1'b0;
          end else if (fr[0] == 8'h05 && fr.size() >= 2 && wip_left > 0) wip_left--;
        end
      end
      ps = spi_sck; pc = spi_cs_n;
    end
  end

  // ---------------- byte source ----------------
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  int  hs_cnt = 0, hs_base = 0, stall_at = 0, stall_len = 0, stall_base = 0;
  int  stall_obs = 0, stall_bad = 0;
  bit  gaps = 1'b0;

  initial begin
    bit hs_pending, stalling;
    wr_valid = 1'b0; wr_data = '0; hs_pending = 1'b0;
    forever begin
      @(negedge clk); #3;
      if (hs_pending && src_q.size() > 0) begin void'(src_q.pop_front()); hs_cnt++; end
      stalling = stall_len > 0 && (hs_cnt - hs_base) == stall_at && (stall_obs - stall_base) < stall_len;
      if (src_q.size() > 0 && !stalling && (!gaps || $urandom_range(0, 3) != 0)) begin
        wr_valid = 1'b1; wr_data = src_q[0];
      end else wr_valid = 1'b0;
      if (stalling && wr_ready === 1'b1) begin
        stall_obs++;
        if (spi_sck !== 1'b0 || spi_cs_n !== 1'b0) stall_bad++;
      end
      hs_pending = wr_valid && wr_ready === 1'b1 && rst === 1'b0;
    end
  end

  // ---------------- activity monitor ----------------
  int done_cyc = 0, err_cyc = 0, busy_cyc = 0, cslow_cyc = 0, ready_cyc = 0, dbl = 0, ready_bad = 0;
  initial begin
    bit pd, pe;
    pd = 1'b0; pe = 1'b0;
    forever begin
      @(negedge clk); #3;
      if (done === 1'b1) done_cyc++;
      if (err === 1'b1) err_cyc++;
      if (busy === 1'b1) busy_cyc++;
      if (spi_cs_n === 1'b0) cslow_cyc++;
      if (wr_ready === 1'b1) ready_cyc++;
      if ((done === 1'b1 && pd) || (err === 1'b1 && pe)) dbl++;
      if (wr_ready === 1'b1 && spi_cs_n !== 1'b0) ready_bad++;
      pd = (done === 1'b1); pe = (err === 1'b1);
    end
  end

  // ---------------- helpers ----------------
  task automatic step(); @(negedge clk); #2; endtask

  task automatic issue(input logic [23:0] a, input logic [8:0] l);
    addr = a; len = l; start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic wait_end(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && err !== 1'b1 && cyc < LIMIT) begin step(); cyc++; end
  endtask

  task automatic fill(input int l, input int mode, input logic [7:0] seed);
    exp_q.delete();
    for (int i = 0; i < l; i++) begin
      exp_q.push_back(mode == 1 ? 8'(seed + 8'(i)) : (mode == 2 ? seed : 8'($urandom)));
      src_q.push_back(exp_q[i]);
    end
  endtask

  task automatic check_mem(input string tag, input logic [23:0] a);
    int bad;
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (!mem.exists(int'(a) + i) || mem[int'(a) + i] !== exp_q[i]) bad++;
    chk(tag, bad, 0);
  endtask

  function automatic int count_op(input int from, input int op);
    int n;
    n = 0;
    for (int i = from; i < log_op.size(); i++) if (log_op[i] == op) n++;
    return n;
  endfunction

  function automatic logic [23:0] rand_addr(input int l);
    logic [23:0] a;
    a[23:8] = 16'($urandom_range(16'h0100, 16'hFFFF));
    a[7:0]  = 8'($urandom_range(0, 256 - l));
    return a;
  endfunction

  // Runs one accepted request end to end and checks the common outcome.
  task automatic run_ok(input string tag, input logic [23:0] a, input int l, input int wip);
    int lb, d0, e0, h0, cyc;
    wip_cfg = wip; lb = log_op.size(); d0 = done_cyc; e0 = err_cyc; h0 = hs_cnt; hs_base = hs_cnt;
    issue(a, 9'(l));
    chk({tag, "_busy"}, busy, 1);
    wait_end(cyc);
    chk({tag, "_in_time"}, cyc < LIMIT, 1);
    repeat (3) step();
    chk({tag, "_done_pulses"}, done_cyc - d0, 1);
    chk({tag, "_err_pulses"}, err_cyc - e0, 0);
    chk({tag, "_handshakes"}, hs_cnt - h0, l);
    chk({tag, "_rdsr_frames"}, count_op(lb, 5), wip + 1);
    chk({tag, "_idle_pins"}, {busy, spi_cs_n, spi_sck}, 3'b010);
    check_mem({tag, "_mem"}, a);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lb, d0, e0, b0, c0, r0, cyc, l;
    logic [23:0] a;
    rst = 1'b1; start = 1'b0; addr = '0; len = '0;
    repeat (4) step();
    chk("reset_pins", {spi_sck, spi_cs_n, spi_mosi, wr_ready, busy, done, err}, 7'b0100000);
    rst = 1'b0;
    step();

    // 1: single byte, three busy polls
    lb = log_op.size();
    fill(1, 2, 8'hA5);
    run_ok("t1", 24'h000010, 1, 3);
    chk("t1_nframes", log_op.size() - lb, 6);
    chk("t1_ops", {8'(log_op[lb]), 8'(log_op[lb+1]), 8'(log_op[lb+2]), 8'(log_op[lb+5])}, 32'h06020505);
    chk("t1_prog_frame", {last_prog[0], last_prog[1], last_prog[2], last_prog[3], last_prog[4]}, 40'h02000010A5);

    // 2: full page, incrementing data, ragged source
    gaps = 1'b1;
    fill(256, 1, 8'($urandom));
    run_ok("t2", 24'h001200, 256, $urandom_range(0, 4));
    chk("t2_sck_rises", last_rises, 2080);
    gaps = 1'b0;

    // 3: rejected requests (page crossing, len 0, len 257)
    e0 = err_cyc; b0 = busy_cyc; c0 = cslow_cyc; r0 = ready_cyc; lb = log_op.size();
    issue(24'h0000F0, 9'h020);
    chk("t3_err_next_cycle", {err, busy}, 2'b10);
    repeat (20) step();
    issue(24'h000300, 9'd0);
    chk("t3_len0_err", err, 1);
    repeat (3) step();
    issue(24'h000400, 9'd257);
    chk("t3_len257_err", err, 1);
    repeat (3) step();
    chk("t3_err_pulses", err_cyc - e0, 3);
    chk("t3_quiet", {busy_cyc - b0, cslow_cyc - c0, ready_cyc - r0, log_op.size() - lb}, 0);

    // boundary: last byte of a page is accepted
    fill(1, 0, 8'h00);
    run_ok("t3b", 24'h0007FF, 1, 0);

    // 4: 50-cycle source stall before the third byte
    stall_at = 2; stall_len = 50; stall_base = stall_obs;
    a = rand_addr(4);
    fill(4, 0, 8'h00);
    run_ok("t4", a, 4, $urandom_range(0, 3));
    chk("t4_stall_len", stall_obs - stall_base, 50);
    chk("t4_stall_pins", stall_bad, 0);
    stall_len = 0;

    // 5: WIP never clears -> timeout after POLL_MAX polls
    wip_cfg = 1000; lb = log_op.size(); d0 = done_cyc; e0 = err_cyc;
    a = rand_addr(2);
    fill(2, 0, 8'h00);
    hs_base = hs_cnt;
    issue(a, 9'd2);
    wait_end(cyc);
    chk("t5_in_time", cyc < LIMIT, 1);
    chk("t5_err_now", {err, done, spi_cs_n}, 3'b101);
    repeat (3) step();
    chk("t5_rdsr_frames", count_op(lb, 5), POLL_MAX);
    chk("t5_pulses", {8'(err_cyc - e0), 8'(done_cyc - d0)}, 16'h0100);

    // 6: reset in the middle of the data phase, then a clean request
    wip_cfg = 1;
    l = $urandom_range(6, 12);
    fill(l, 0, 8'h00);
    hs_base = hs_cnt;
    issue(rand_addr(l), 9'(l));
    cyc = 0;
    while (hs_cnt - hs_base < 3 && cyc < LIMIT) begin step(); cyc++; end
    chk("t6_reached_data", cyc < LIMIT, 1);
    rst = 1'b1;
    step();
    chk("t6_reset_pins", {spi_cs_n, spi_sck, busy, wr_ready}, 4'b1000);
    rst = 1'b0;
    src_q.delete();
    repeat (2) step();
    l = $urandom_range(1, 16);
    fill(l, 0, 8'h00);
    run_ok("t6", rand_addr(l), l, $urandom_range(0, 2));

    chk("pulse_width", dbl, 0);
    chk("ready_outside_frame", ready_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
